// File: rtl/nibble_add_arbiter_if.sv
// Requester/result handshake and shared 4-bit adder hookup for nibble_add_arbiter.
// The slave side is the arbiter; the master side is the requesters plus the adder.
interface nibble_add_arbiter_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic [1:0]   req;
  logic [W-1:0] a0;
  logic [W-1:0] b0;
  logic [W-1:0] a1;
  logic [W-1:0] b1;
  logic [1:0]   ack;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         result_cout;
  logic         result_id;
  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic         add_cin;
  logic [3:0]   add_sum;
  logic         add_cout;

  modport slave (
    input  req, a0, b0, a1, b1, add_sum, add_cout,
    output ack, busy, done, result, result_cout, result_id, add_a, add_b, add_cin
  );

  modport master (
    output req, a0, b0, a1, b1, add_sum, add_cout,
    input  ack, busy, done, result, result_cout, result_id, add_a, add_b, add_cin
  );
endinterface

// File: rtl/nibble_add_arbiter.sv
// Round-robin arbiter that feeds two requesters' operands nibble-serially through
// one shared external 4-bit adder, chaining the carry through a register.
//
//   state  | meaning
//   S_IDLE | waiting for a request; grant and capture on the edge req != 0
//   S_RUN  | one nibble per clock through the shared adder, LSB nibble first
//   S_DONE | done pulse; result/result_cout/result_id valid and held
module nibble_add_arbiter #(
  parameter int NIBBLES = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  nibble_add_arbiter_if.slave bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state_q;
  logic [W-1:0]  op_a_q;
  logic [W-1:0]  op_b_q;
  logic [W-1:0]  result_q;
  logic [CW-1:0] cnt_q;
  logic          gnt_id_q;
  logic          last_id_q;
  logic [1:0]    ack_q;
  logic          busy_q;
  logic          done_q;
  logic          result_cout_q;
  logic          result_id_q;
  logic [3:0]    add_a_q;
  logic [3:0]    add_b_q;
  logic          add_cin_q;

  logic          gnt_id_d;
  logic [W-1:0]  cap_a_d;
  logic [W-1:0]  cap_b_d;
  logic [W+3:0]  res_shift;
  logic          last_nib;

  // On a tie the requester that did not finish last wins.
  always_comb begin
    gnt_id_d = bus.req[1] & (~bus.req[0] | ~last_id_q);
    cap_a_d  = gnt_id_d ? bus.a1 : bus.a0;
    cap_b_d  = gnt_id_d ? bus.b1 : bus.b0;
  end

  // Sum nibbles enter at the top and walk down; after NIBBLES shifts they are in place.
  assign res_shift = {bus.add_sum, result_q};
  assign last_nib  = (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      op_a_q        <= '0;
      op_b_q        <= '0;
      result_q      <= '0;
      cnt_q         <= '0;
      gnt_id_q      <= 1'b0;
      last_id_q     <= 1'b1;
      ack_q         <= 2'b00;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      result_cout_q <= 1'b0;
      result_id_q   <= 1'b0;
      add_a_q       <= '0;
      add_b_q       <= '0;
      add_cin_q     <= 1'b0;
    end else begin
      ack_q  <= 2'b00;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.req != 2'b00) begin
            gnt_id_q  <= gnt_id_d;
            ack_q     <= gnt_id_d ? 2'b10 : 2'b01;
            busy_q    <= 1'b1;
            op_a_q    <= cap_a_d >> 4;
            op_b_q    <= cap_b_d >> 4;
            add_a_q   <= cap_a_d[3:0];
            add_b_q   <= cap_b_d[3:0];
            add_cin_q <= 1'b0;
            cnt_q     <= CNT_LOAD;
            state_q   <= S_RUN;
          end
        end
        S_RUN: begin
          result_q <= res_shift[W+3:4];
          op_a_q   <= op_a_q >> 4;
          op_b_q   <= op_b_q >> 4;
          if (last_nib) begin
            add_a_q       <= '0;
            add_b_q       <= '0;
            add_cin_q     <= 1'b0;
            result_cout_q <= bus.add_cout;
            result_id_q   <= gnt_id_q;
            last_id_q     <= gnt_id_q;
            done_q        <= 1'b1;
            state_q       <= S_DONE;
          end else begin
            add_a_q   <= op_a_q[3:0];
            add_b_q   <= op_b_q[3:0];
            add_cin_q <= bus.add_cout;
            cnt_q     <= cnt_q - CW'(1);
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.ack         = ack_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.result      = result_q;
  assign bus.result_cout = result_cout_q;
  assign bus.result_id   = result_id_q;
  assign bus.add_a       = add_a_q;
  assign bus.add_b       = add_b_q;
  assign bus.add_cin     = add_cin_q;
endmodule

// File: tb/tb_nibble_add_arbiter.sv
// Bench for nibble_add_arbiter: a timeline model of the 4-nibble instance checked on
// every falling edge, plus directed scenarios with hand-computed literal results.
module tb_nibble_add_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  nibble_add_arbiter_if #(.NIBBLES(4)) ifc4 ();
  nibble_add_arbiter_if #(.NIBBLES(1)) ifc1 ();

  nibble_add_arbiter #(.NIBBLES(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(ifc4));
  nibble_add_arbiter #(.NIBBLES(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(ifc1));

  // Behavioural shared adders.
  assign {ifc4.add_cout, ifc4.add_sum} = 5'(ifc4.add_a) + 5'(ifc4.add_b) + 5'(ifc4.add_cin);
  assign {ifc1.add_cout, ifc1.add_sum} = 5'(ifc1.add_a) + 5'(ifc1.add_b) + 5'(ifc1.add_cin);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Timeline model: phase 0 idle, 1..N drives nibble phase-1, N+1 is the done cycle.
  int          m_phase = 0;
  logic        m_last = 1'b1;
  logic        m_id = 1'b0;
  logic [15:0] m_a = '0, m_b = '0;
  logic [16:0] m_sum = '0;
  logic [15:0] m_res = '0;
  logic        m_rc = 1'b0, m_rid = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_phase = 0; m_last = 1'b1; m_res = '0; m_rc = 1'b0; m_rid = 1'b0;
        chk("rst_ack", ifc4.ack, 0);
        chk("rst_busy", ifc4.busy, 0);
        chk("rst_done", ifc4.done, 0);
        chk("rst_result", {ifc4.result_cout, ifc4.result_id, ifc4.result}, 0);
        chk("rst_add", {ifc4.add_a, ifc4.add_b, ifc4.add_cin}, 0);
      end else begin
        int          k;
        int          msk;
        logic [1:0]  e_ack;
        logic [3:0]  e_a, e_b;
        logic        e_cin;
        e_ack = (m_phase == 1) ? (m_id ? 2'b10 : 2'b01) : 2'b00;
        e_a = '0; e_b = '0; e_cin = 1'b0;
        if (m_phase >= 1 && m_phase <= N) begin
          k     = m_phase - 1;
          msk   = (1 << (4 * k)) - 1;
          e_a   = 4'((int'(m_a) >> (4 * k)) & 15);
          e_b   = 4'((int'(m_b) >> (4 * k)) & 15);
          e_cin = 1'(((int'(m_a) & msk) + (int'(m_b) & msk)) >> (4 * k));
        end
        chk("m_ack", ifc4.ack, e_ack);
        chk("m_busy", ifc4.busy, m_phase != 0);
        chk("m_done", ifc4.done, m_phase == N + 1);
        chk("m_add", {ifc4.add_a, ifc4.add_b, ifc4.add_cin}, {e_a, e_b, e_cin});
        if (m_phase == 0 || m_phase == N + 1)
          chk("m_result", {ifc4.result_cout, ifc4.result_id, ifc4.result}, {m_rc, m_rid, m_res});
        if (m_phase == 0) begin
          if (ifc4.req != 2'b00) begin
            m_id    = (ifc4.req == 2'b11) ? ~m_last : ifc4.req[1];
            m_a     = m_id ? ifc4.a1 : ifc4.a0;
            m_b     = m_id ? ifc4.b1 : ifc4.b0;
            m_sum   = 17'(m_a) + 17'(m_b);
            m_phase = 1;
          end
        end else if (m_phase == N) begin
          m_res = m_sum[15:0]; m_rc = m_sum[16]; m_rid = m_id; m_last = m_id;
          m_phase = N + 1;
        end else if (m_phase == N + 1) begin
          m_phase = 0;
        end else begin
          m_phase++;
        end
      end
    end
  end

  // Called one step after the capture edge; returns edges until done is seen.
  task automatic wait_done(input string nm, output int lat);
    lat = 0;
    while (!ifc4.done && lat < 20) begin
      cyc();
      lat++;
    end
    chk({nm, "_latency"}, lat, N);
  endtask

  task automatic op4(input logic [1:0] r, input logic [15:0] a0, b0, a1, b1);
    ifc4.req = r; ifc4.a0 = a0; ifc4.b0 = b0; ifc4.a1 = a1; ifc4.b1 = b1;
  endtask

  initial begin
    int lat;
    int grants[$];
    int done_t[$];

    op4(2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
    ifc1.req = 2'b00; ifc1.a0 = '0; ifc1.b0 = '0; ifc1.a1 = '0; ifc1.b1 = '0;
    cyc(); cyc(); cyc();
    chk("reset_busy", ifc4.busy, 0);
    chk("reset_result", ifc4.result, 0);
    rst_n = 1'b1;
    cyc();

    // 1: single request from requester 0
    op4(2'b01, 16'h1234, 16'h0FFF, 16'h0, 16'h0);
    cyc();
    chk("t1_ack", ifc4.ack, 2'b01);
    ifc4.req = 2'b00;
    wait_done("t1", lat);
    chk("t1_result", ifc4.result, 16'h2233);
    chk("t1_cout", ifc4.result_cout, 0);
    chk("t1_id", ifc4.result_id, 0);
    cyc(); cyc();

    // 2: carry ripples through every nibble
    op4(2'b10, 16'h0, 16'h0, 16'hFFFF, 16'h0001);
    cyc();
    chk("t2_ack", ifc4.ack, 2'b10);
    ifc4.req = 2'b00;
    for (int k = 0; k < N; k++) begin
      chk("t2_cin", ifc4.add_cin, (k > 0) ? 1 : 0);
      cyc();
    end
    chk("t2_done", ifc4.done, 1);
    chk("t2_result", ifc4.result, 16'h0000);
    chk("t2_cout", ifc4.result_cout, 1);
    chk("t2_id", ifc4.result_id, 1);
    cyc(); cyc();

    // 3: both requests held from reset alternate 0,1,0,1
    rst_n = 1'b0;
    op4(2'b11, 16'h00FF, 16'h0F01, 16'h8000, 16'h8000);
    cyc(); cyc();
    rst_n = 1'b1;
    for (int c = 0; c < 40 && done_t.size() < 4; c++) begin
      cyc();
      if (ifc4.ack != 2'b00) grants.push_back(int'(ifc4.ack == 2'b10));
      if (ifc4.done) begin
        done_t.push_back(c);
        chk("t3_rid", ifc4.result_id, (done_t.size() - 1) % 2);
        chk("t3_result", {ifc4.result_cout, ifc4.result},
            ((done_t.size() - 1) % 2) ? 17'h10000 : 17'h01000);
      end
    end
    ifc4.req = 2'b00;
    chk("t3_ndone", done_t.size(), 4);
    chk("t3_ngrant", grants.size(), 4);
    foreach (grants[i]) chk("t3_grant", grants[i], i % 2);
    for (int i = 1; i < done_t.size(); i++) chk("t3_spacing", done_t[i] - done_t[i-1], N + 2);
    cyc(); cyc();

    // 4: late request from requester 1 waits for IDLE
    op4(2'b01, 16'h0101, 16'h0202, 16'h1000, 16'h2000);
    cyc();
    chk("t4_ack0", ifc4.ack, 2'b01);
    ifc4.req = 2'b00;
    cyc(); cyc();
    ifc4.req = 2'b10;
    for (int c = 3; c <= 6; c++) begin
      cyc();
      chk("t4_ack", ifc4.ack, (c == 6) ? 2'b10 : 2'b00);
    end
    ifc4.req = 2'b00;
    wait_done("t4", lat);
    chk("t4_result", {ifc4.result_id, ifc4.result}, 17'h13000);
    cyc(); cyc();

    // 5: finish a requester-0 op, then abort another with reset mid-run
    op4(2'b01, 16'h0003, 16'h0004, 16'h0, 16'h0);
    cyc();
    ifc4.req = 2'b00;
    wait_done("t5a", lat);
    chk("t5a_result", ifc4.result, 16'h0007);
    cyc(); cyc();
    op4(2'b01, 16'h1234, 16'h1111, 16'h0, 16'h0);
    cyc();
    ifc4.req = 2'b00;
    cyc(); cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_busy", ifc4.busy, 0);
    chk("t5_async_add", {ifc4.add_a, ifc4.add_b, ifc4.add_cin}, 0);
    chk("t5_async_result", ifc4.result, 0);
    cyc(); cyc();
    chk("t5_no_done", ifc4.done, 0);
    rst_n = 1'b1;
    op4(2'b11, 16'h0001, 16'h0001, 16'h5555, 16'h1111);
    cyc();
    chk("t5_ack", ifc4.ack, 2'b01);
    ifc4.req = 2'b00;
    wait_done("t5", lat);
    chk("t5_result", {ifc4.result_cout, ifc4.result_id, ifc4.result}, 18'h00002);
    cyc(); cyc();

    // 6: single-nibble instance
    ifc1.req = 2'b01; ifc1.a0 = 4'hF; ifc1.b0 = 4'h1;
    cyc();
    chk("t6_ack", ifc1.ack, 2'b01);
    ifc1.req = 2'b00;
    lat = 0;
    while (!ifc1.done && lat < 20) begin
      cyc();
      lat++;
    end
    chk("t6_latency", lat, 1);
    chk("t6_result", ifc1.result, 4'h0);
    chk("t6_cout", ifc1.result_cout, 1);
    chk("t6_id", ifc1.result_id, 0);
    cyc(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end
endmodule
